mult_seq_ctrl: RTL
==================

Name: mult_seq_ctrl

Overview:
- Sequencer that computes an unsigned word x word -> 2*word multiply by time-sharing one external word-wide adder, using shift-and-add, one adder use per cycle.
- Sits beside the EX stage. It feeds the multiply unit behind MULTU and drives hi/lo.
- Drives the adder's a/b inputs and consumes its result combinationally in the same cycle.
- The adder has no carry out, so the carry is derived inside this block.

Parameters:
- word, 32, operand width; the product is 2*word.
- cnt_w, 6, iteration counter width; must satisfy 2^cnt_w > word.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset; sampled on the clk edge
- start  input  1  request; sampled only in IDLE or DONE
- op_a  input  word  multiplicand; captured on the accept edge
- op_b  input  word  multiplier; captured on the accept edge
- add_a  output  word  to adder input a
- add_b  output  word  to adder input b
- add_result  input  word  from adder, equal to add_a+add_b mod 2^word; combinational
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when the product is valid
- hi  output  word  product[2*word-1:word]
- lo  output  word  product[word-1:0]

Behaviour:
- Reset: when rst_n=0 at a clk edge:
  - state=IDLE, count=0, busy=0, done=0.
  - hi=0, lo=0, internal multiplicand register M=0.
  - add_a=0, add_b=0 (combinational from cleared registers).
  - Reset overrides everything, including reset mid-RUN: the partial product is discarded and no done pulse follows.
- States: IDLE, RUN, DONE.
- Accept: in IDLE or DONE with start=1 at an edge:
  - M<=op_a, hi<=0, lo<=op_b, count<=0, state<=RUN.
  - In the accepting cycle busy=0 and done is unaffected.
- RUN datapath (combinational):
  - add_a=hi.
  - add_b = lo[0] ? M : 0.
  - carry = lo[0] & (add_result < hi), unsigned compare.
- RUN update (each edge):
  - {hi,lo} <= {carry, add_result, lo} >> 1, i.e. hi <= {carry, add_result[word-1:1]} and lo <= {add_result[0], lo[word-1:1]}.
  - count <= count+1.
- RUN exit:
  - When count==word-1 at an edge, the update above still applies and state<=DONE.
  - Exactly word RUN cycles.
- busy=1 iff state==RUN.
- done=1 iff state==DONE. DONE lasts one cycle unless start is accepted in it (back-to-back allowed).
- DONE with start=0 -> IDLE.
- Latency: start accepted at edge E0; done high in the cycle after edge E0+word; hi/lo valid from that cycle.
- Result hold: hi/lo hold their value in DONE and IDLE until the next accept.
- start is ignored while busy: no restart, operands are not recaptured, and the current product is unaffected.
- Outside RUN, add_a and add_b keep the same formula. Their values are don't-care to the adder, but they must be deterministic and not X after reset.
- Operand changes after the accept edge have no effect.
- Arithmetic: unsigned only, no overflow possible. Zero operands take the full word cycles (no early exit).

Test Plan (word=32):
- Basic: reset, then start with op_a=3, op_b=5 -> busy for 32 cycles; done pulses once; {hi,lo}=0x00000000_0000000F; hi/lo held 10 cycles later.
- Carry path: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Exercises carry=1 on many iterations.
- Zero and identity:
  - op_a=0, op_b=0x12345678 -> hi=0, lo=0, still 32 busy cycles.
  - op_a=0x80000000, op_b=2 -> hi=0x00000001, lo=0.
- Start while busy: start with 7*9; at busy cycle 10, pulse start with op_a=1, op_b=1 -> ignored; result 0x3F after the same latency; exactly one done pulse.
- Reset mid-operation:
  - Start 0xFFFF*0xFFFF, drive rst_n=0 for one edge at busy cycle 16 -> next cycle busy=0, done=0, hi=lo=0, and no done pulse appears.
  - A new start then yields 0x00000000_FFFE0001.
- Back-to-back: hold start=1 with 6*7, then switch operands to 10*10 in the DONE cycle -> first done shows 0x2A; DONE->RUN directly (busy high the next cycle); second done shows 0x64 exactly 33 cycles later.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Shift-and-add unsigned multiplier sequencer: one external adder use per cycle,
// producing a 2*word product in hi/lo after exactly word iterations.
module mult_seq_ctrl #(
  parameter int unsigned word  = 32,
  parameter int unsigned cnt_w = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [word-1:0] op_a,
  input  logic [word-1:0] op_b,
  output logic [word-1:0] add_a,
  output logic [word-1:0] add_b,
  input  logic [word-1:0] add_result,
  output logic            busy,
  output logic            done,
  output logic [word-1:0] hi,
  output logic [word-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [cnt_w-1:0]  count_q, count_d;
  logic [word-1:0]   hi_q, hi_d;
  logic [word-1:0]   lo_q, lo_d;
  logic [word-1:0]   m_q, m_d;
  logic              carry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
    end
  end

  always_comb begin
    // The adder has no carry out; a wrapped sum is smaller than either addend.
    add_a = hi_q;
    add_b = lo_q[0] ? m_q : '0;
    carry = lo_q[0] & (add_result < hi_q);

    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          m_d     = op_a;
          hi_d    = '0;
          lo_d    = op_b;
          count_d = '0;
          state_d = StRun;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        hi_d    = {carry, add_result[word-1:1]};
        lo_d    = {add_result[0], lo_q[word-1:1]};
        count_d = count_q + cnt_w'(1);
        if (count_q == cnt_w'(word - 1)) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
